// File: rtl/spm_controller.sv
// spm_controller: sequencer for the N-bit serial-parallel multiplier array.
// Optional SPM_SIGNED_EN macro selects two's-complement operands with a sign-fix state.
module spm_controller #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic           spm_clr,
   output logic           spm_en,
   output logic [N-1:0]   spm_a,
   output logic           spm_x,
   input  logic           spm_p
);
   localparam int CNT_W = $clog2(2*N) + 1;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] DONE  = 3'd4;
`ifdef SPM_SIGNED_EN
   localparam logic [2:0] FIX   = 3'd3;
   logic neg;
   wire [N-1:0] a_abs = a_in[N-1] ? -a_in : a_in;
   wire [N-1:0] b_abs = b_in[N-1] ? -b_in : b_in;
`else
   wire [N-1:0] a_abs = a_in;
   wire [N-1:0] b_abs = b_in;
`endif
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     b_sh;
   // b_sh drains LSB first, so once empty it naturally supplies the trailing zeros
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         b_sh    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         spm_clr <= 1'b0;
         spm_en  <= 1'b0;
         spm_a   <= '0;
         spm_x   <= 1'b0;
`ifdef SPM_SIGNED_EN
         neg     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= CLEAR;
               busy    <= 1'b1;
               spm_clr <= 1'b1;
               spm_a   <= a_abs;
               b_sh    <= b_abs;
`ifdef SPM_SIGNED_EN
               neg     <= a_in[N-1] ^ b_in[N-1];
`endif
            end
            CLEAR: begin
               state   <= RUN;
               spm_clr <= 1'b0;
               spm_en  <= 1'b1;
               spm_x   <= b_sh[0];
               b_sh    <= b_sh >> 1;
               cnt     <= '0;
            end
            RUN: begin
               product <= {spm_p, product[2*N-1:1]};
               if (cnt == CNT_W'(2*N-1)) begin
                  spm_en <= 1'b0;
                  spm_x  <= 1'b0;
`ifdef SPM_SIGNED_EN
                  state  <= FIX;
`else
                  state  <= DONE;
                  done   <= 1'b1;
`endif
               end else begin
                  cnt   <= cnt + 1'b1;
                  spm_x <= b_sh[0];
                  b_sh  <= b_sh >> 1;
               end
            end
`ifdef SPM_SIGNED_EN
            FIX: begin
               product <= neg ? -product : product;
               done    <= 1'b1;
               state   <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spm_controller.sv
// tb_spm_controller: directed bench for spm_controller with a behavioural SPM array model.
// Default build checks unsigned mode; define SPM_SIGNED_EN for the signed vectors.
module tb_spm_controller;
   localparam int N = 8;
`ifdef SPM_SIGNED_EN
   localparam int LAT = 2*N + 3;
`else
   localparam int LAT = 2*N + 2;
`endif
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [N-1:0] a_in = '0, b_in = '0, spm_a;
   logic busy, done, spm_clr, spm_en, spm_x, spm_p;
   logic [2*N-1:0] product;
   int checks = 0, errors = 0, k;

   spm_controller #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .product(product), .spm_clr(spm_clr),
      .spm_en(spm_en), .spm_a(spm_a), .spm_x(spm_x), .spm_p(spm_p)
   );

   always #5 clk = ~clk;

   // array model: product bit c of A * (serial bits received so far)
   logic [31:0] xv = '0, full;
   int c = 0;
   assign full  = 32'(spm_a) * (xv | (32'(spm_x) << c));
   assign spm_p = spm_en ? full[c] : 1'b0;
   always @(posedge clk) begin
      if (spm_clr) begin
         xv <= '0;
         c  <= 0;
      end else if (spm_en) begin
         xv <= xv | (32'(spm_x) << c);
         c  <= c + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [2*N-1:0] exp, input bit hold);
      a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      k = 1;
      chk({tag, "_clr"}, {spm_clr, spm_en}, 32'b10);
      while (!done && k < 40) begin
         @(posedge clk); #1;
         k++;
         if (hold && k == 6) a_in = ~a;
      end
      chk({tag, "_lat"}, k, LAT);
      chk({tag, "_prod"}, product, exp);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle"}, {busy, done}, 32'b00);
   endtask

   initial begin
      #12;
      chk("rst_ctl", {busy, done, spm_clr, spm_en, spm_x}, 32'b0);
      chk("rst_prod", product, 32'h0);
      chk("rst_a", spm_a, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
`ifdef SPM_SIGNED_EN
      run("neg3x5", 8'hFD, 8'h05, 16'hFFF1, 1'b0);
      run("m128sq", 8'h80, 8'h80, 16'h4000, 1'b0);
      run("m128x127", 8'h80, 8'h7F, 16'hC080, 1'b0);
      run("pos", 8'h07, 8'h09, 16'h003F, 1'b0);
`else
      run("ffxff", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
      run("zero", 8'h00, 8'h5A, 16'h0000, 1'b0);
      run("one", 8'h01, 8'hA5, 16'h00A5, 1'b0);
      run("b2b", 8'h12, 8'h34, 16'h03A8, 1'b0);
      run("hold", 8'h03, 8'h07, 16'h0015, 1'b1);
      k = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) k++;
      end
      chk("no_extra_done", k, 0);
`endif
      // reset asserted during RUN cycle c=5 (overall cycle 7)
      a_in = 8'h0B; b_in = 8'h0D; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctl", {busy, spm_en, done}, 32'b000);
      chk("mid_rst_prod", product, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run("after_rst", 8'h0B, 8'h0D, 16'h008F, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
